// File: rtl/macc_mon_pkg.sv
// macc_mon_pkg: shared defaults and the saturating counter helper for the MAC error monitor
package macc_mon_pkg;

    localparam int SIZEIN_D  = 16;
    localparam int SIZEOUT_D = 40;
    localparam int COEF_D    = 29;
    localparam int CNTW_D    = 16;

    // Increment v unless it already holds the all-ones value of a w-bit counter (w <= 32)
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] top;
        top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= top) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/macc_golden_model.sv
// macc_golden_model: bit-exact shadow of the shift-add MAC pipeline using a true multiply
module macc_golden_model
    import macc_mon_pkg::*;
#(
    parameter int SIZEIN  = SIZEIN_D,
    parameter int SIZEOUT = SIZEOUT_D,
    parameter int COEF    = COEF_D
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ce,
    input  logic                      sload,
    input  logic signed [SIZEIN-1:0]  a,
    output logic                      sload_d1,
    output logic signed [SIZEOUT-1:0] gold
);

    localparam int PW = 2 * SIZEIN;
    localparam logic signed [SIZEIN-1:0] COEF_S = SIZEIN'(COEF);

    logic signed [SIZEIN-1:0]  a_d1;
    logic signed [SIZEOUT-1:0] prod_d2;
    logic signed [PW-1:0]      prod;

    assign prod = PW'(a_d1) * PW'(COEF_S);

    // Three-stage pipeline matching the MAC register for register; frozen while ce is low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_d1     <= '0;
            sload_d1 <= 1'b0;
            prod_d2  <= '0;
            gold     <= '0;
        end else if (ce) begin
            a_d1     <= a;
            sload_d1 <= sload;
            prod_d2  <= SIZEOUT'(prod);
            gold     <= (sload_d1 ? '0 : gold) + prod_d2;
        end
    end

endmodule

// File: rtl/macc_err_monitor.sv
// macc_err_monitor: compares the MAC result against a golden model and scores mismatches
module macc_err_monitor
    import macc_mon_pkg::*;
#(
    parameter int SIZEIN  = SIZEIN_D,
    parameter int SIZEOUT = SIZEOUT_D,
    parameter int COEF    = COEF_D,
    parameter int CNTW    = CNTW_D
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ce,
    input  logic                      sload,
    input  logic signed [SIZEIN-1:0]  a,
    input  logic signed [SIZEOUT-1:0] accum_out,
    input  logic                      clr,
    output logic                      armed,
    output logic                      err_pulse,
    output logic                      err_sticky,
    output logic [CNTW-1:0]           err_count,
    output logic [CNTW-1:0]           sample_count,
    output logic [CNTW-1:0]           first_err_idx,
    output logic [SIZEOUT-1:0]        first_err_xor
);

    logic                      sload_d1;
    logic signed [SIZEOUT-1:0] gold;
    logic                      cmp;
    logic                      mismatch;
    logic [31:0]               sc_next;
    logic [31:0]               ec_next;

    macc_golden_model #(
        .SIZEIN (SIZEIN),
        .SIZEOUT(SIZEOUT),
        .COEF   (COEF)
    ) u_gold (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .sload   (sload),
        .a       (a),
        .sload_d1(sload_d1),
        .gold    (gold)
    );

    assign cmp      = ce & armed;
    assign mismatch = accum_out != gold;
    assign sc_next  = sat_inc(32'(sample_count), CNTW);
    assign ec_next  = sat_inc(32'(err_count), CNTW);

    // The MAC accumulator is meaningless until its first restart, so arm on the first one
    always_ff @(posedge clk) begin
        if (!rst_n)
            armed <= 1'b0;
        else if (ce && sload_d1)
            armed <= 1'b1;
    end

    // Per-cycle mismatch flag; clr does not mask it
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_pulse <= 1'b0;
        else
            err_pulse <= cmp & mismatch;
    end

    // Saturating counters and first-failure capture; clr overrides any concurrent update
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            err_sticky    <= 1'b0;
            err_count     <= '0;
            sample_count  <= '0;
            first_err_idx <= '0;
            first_err_xor <= '0;
        end else if (cmp) begin
            sample_count <= sc_next[CNTW-1:0];
            if (mismatch) begin
                err_count  <= ec_next[CNTW-1:0];
                err_sticky <= 1'b1;
                if (!err_sticky) begin
                    first_err_idx <= sample_count;
                    first_err_xor <= gold ^ accum_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_macc_err_monitor.sv
// tb_macc_err_monitor: directed scoreboard bench driving a behavioural MAC with fault injection
module tb_macc_err_monitor;

    localparam int SA = 0, SP = 1, SS = 2, SEC = 3, SSC = 4, SFI = 5, SFX = 6, SG = 7, SSAT = 8, SPD = 9;

    typedef struct {
        int          cyc;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ce = 1'b0;
    logic               sload = 1'b0;
    logic               clr = 1'b0;
    logic signed [15:0] a = '0;
    logic        [39:0] accum_out;

    logic        armed, err_pulse, err_sticky;
    logic [15:0] err_count, sample_count, first_err_idx;
    logic [39:0] first_err_xor;
    logic        s_armed, s_err_pulse, s_err_sticky;
    logic [3:0]  s_err_count, s_sample_count, s_first_err_idx;
    logic [39:0] s_first_err_xor;

    logic signed [15:0] m_a1 = '0;
    logic               m_s1 = 1'b0;
    logic signed [39:0] m_p2 = '0;
    logic signed [39:0] m_acc = '0;
    logic        [39:0] mask = '0;
    logic               flip = 1'b0;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    macc_err_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sload(sload), .a(a), .accum_out(accum_out), .clr(clr),
        .armed(armed), .err_pulse(err_pulse), .err_sticky(err_sticky), .err_count(err_count),
        .sample_count(sample_count), .first_err_idx(first_err_idx), .first_err_xor(first_err_xor)
    );

    macc_err_monitor #(.CNTW(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sload(sload), .a(a), .accum_out(accum_out), .clr(clr),
        .armed(s_armed), .err_pulse(s_err_pulse), .err_sticky(s_err_sticky), .err_count(s_err_count),
        .sample_count(s_sample_count), .first_err_idx(s_first_err_idx), .first_err_xor(s_first_err_xor)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference MAC the monitor watches; flip corrupts its accumulator, mask corrupts the bus
    always @(posedge clk) begin
        if (ce) begin
            m_a1  <= a;
            m_s1  <= sload;
            m_p2  <= 40'(m_a1) * 40'sd29;
            m_acc <= ((m_s1 ? 40'sd0 : m_acc) + m_p2) ^ 40'(flip);
        end
    end

    assign accum_out = m_acc ^ mask;

    function automatic logic [63:0] act(input int sel);
        case (sel)
            SA:      return {63'b0, armed};
            SP:      return {63'b0, err_pulse};
            SS:      return {63'b0, err_sticky};
            SEC:     return {48'b0, err_count};
            SSC:     return {48'b0, sample_count};
            SFI:     return {48'b0, first_err_idx};
            SFX:     return {24'b0, first_err_xor};
            SG:      return {24'b0, u_dut.u_gold.gold};
            SSAT:    return {60'b0, s_err_count};
            SPD:     return {24'b0, u_dut.u_gold.prod_d2};
            default: return '0;
        endcase
    endfunction

    function automatic string nm(input int sel);
        case (sel)
            SA:      return "armed";
            SP:      return "err_pulse";
            SS:      return "err_sticky";
            SEC:     return "err_count";
            SSC:     return "sample_count";
            SFI:     return "first_err_idx";
            SFX:     return "first_err_xor";
            SG:      return "gold";
            SSAT:    return "sat_err_count";
            SPD:     return "prod_d2";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: pop every expectation due by this cycle and compare it away from the edge
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [63:0] v;
            e = q.pop_front();
            v = act(e.sel);
            total++;
            if (v !== e.exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%0h want=%0h", nm(e.sel), cyc, v, e.exp);
            end
        end
    end

    task automatic chk(input int sel, input logic [63:0] v);
        exp_t e;
        e.cyc = cyc + 1;
        e.sel = sel;
        e.exp = v;
        q.push_back(e);
    endtask

    task automatic step(input logic c, input logic s, input int av);
        ce = c;
        sload = s;
        a = 16'(av);
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(0, 0, 0);
        chk(SA, 0); chk(SP, 0); chk(SEC, 0); chk(SSC, 0); chk(SFX, 0); chk(SG, 0);
        step(1, 0, 0);
        rst_n = 1'b1;
        chk(SA, 0); step(1, 1, 1);
        chk(SA, 1); chk(SSC, 0); step(1, 0, 2);
        chk(SG, 29); chk(SSC, 1); step(1, 0, 3);
        chk(SG, 87); chk(SSC, 2); step(1, 0, 0);
        chk(SG, 174); chk(SSC, 3); chk(SEC, 0); step(1, 0, 4);
        mask = 40'h20;
        chk(SP, 1); chk(SEC, 1); chk(SFX, 40'h20); chk(SFI, 3); chk(SS, 1); chk(SSC, 4); step(1, 0, 5);
        mask = '0;
        chk(SP, 0); chk(SEC, 1); chk(SSC, 5); step(1, 0, 6);
        mask = 40'h1;
        for (int i = 0; i < 5; i++) begin
            chk(SP, 0); chk(SSC, 5); chk(SEC, 1); chk(SA, 1); step(0, 1, i * 7 + 1);
        end
        mask = '0;
        chk(SSC, 6); chk(SEC, 1); chk(SP, 0); step(1, 0, -3);
        chk(SSC, 7); chk(SEC, 1); step(1, 0, 9);
        clr = 1'b1;
        mask = 40'h4;
        chk(SP, 1); chk(SEC, 0); chk(SSC, 0); chk(SS, 0); chk(SFX, 0); chk(SFI, 0); chk(SA, 1);
        step(1, 0, 2);
        clr = 1'b0;
        mask = '0;
        chk(SSC, 1); chk(SP, 0); step(1, 0, 1);
        flip = 1'b1;
        chk(SSC, 2); chk(SEC, 0); step(1, 0, 3);
        flip = 1'b0;
        chk(SP, 1); chk(SEC, 1); chk(SFI, 2); chk(SFX, 1); step(1, 0, 4);
        chk(SEC, 2); step(1, 0, 5);
        chk(SEC, 3); step(1, 1, 6);
        chk(SEC, 4); chk(SSC, 6); step(1, 0, 7);
        chk(SP, 0); chk(SEC, 4); chk(SSC, 7); chk(SFX, 1); chk(SFI, 2); step(1, 0, 8);
        chk(SSC, 8); step(1, 0, -32768);
        chk(SPD, 40'hFF_FFF1_8000); chk(SSC, 9); step(1, 0, 0);
        chk(SEC, 4); step(1, 0, 100);
        chk(SEC, 4); chk(SSC, 11); step(1, 0, 0);
        mask = 40'h1;
        for (int i = 0; i < 14; i++) begin
            chk(SP, 1);
            if (i == 9) chk(SSAT, 14);
            if (i == 13) begin
                chk(SSAT, 15); chk(SEC, 18); chk(SSC, 25);
            end
            step(1, 0, i + 11);
        end
        mask = '0;
        rst_n = 1'b0;
        chk(SA, 0); chk(SEC, 0); chk(SSC, 0); chk(SG, 0); chk(SP, 0); step(1, 0, 7);
        rst_n = 1'b1;
        mask = 40'h1;
        chk(SA, 0); chk(SP, 0); chk(SSC, 0); step(1, 0, 0);
        chk(SP, 0); chk(SEC, 0); step(1, 0, 0);
        mask = '0;
        chk(SA, 0); step(1, 1, 1);
        chk(SA, 1); chk(SSC, 0); step(1, 0, 2);
        chk(SSC, 1); chk(SEC, 0); step(1, 0, 3);
        chk(SSC, 2); step(1, 1, 4);
        chk(SSC, 3); step(1, 1, 5);
        chk(SSC, 4); chk(SA, 1); step(1, 0, 6);
        chk(SSC, 5); step(1, 0, 0);
        chk(SSC, 6); chk(SEC, 0); chk(SS, 0); step(1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/macc_err_monitor.md
# macc_err_monitor

Golden-model checker that sits directly downstream of the shift-add constant-coefficient MAC in the error-insertion datapath. It taps the same `ce`, `sload` and `a` stimulus that drives the MAC and runs a bit-exact shadow accumulator using a true multiply by `COEF`. It compares the MAC's `accum_out` against that model every enabled cycle. It reports per-cycle mismatches, a saturating error count, and a capture of the first failing sample, so that error-injection campaigns can be scored on-chip.

## Interface
Parameters:
- `SIZEIN`, 16, width of the MAC input `a`
- `SIZEOUT`, 40, width of the accumulator
- `COEF`, 29, signed constant the MAC implements (1 − 4 + 32)
- `CNTW`, 16, width of the error and sample counters

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `ce`  in  1  same enable that drives the MAC
- `sload`  in  1  same accumulate-restart strobe that drives the MAC
- `a`  in  SIZEIN  same signed sample that drives the MAC
- `accum_out`  in  SIZEOUT  signed MAC result under test
- `clr`  in  1  synchronous clear of the counters and captures
- `armed`  out  1  comparison is active
- `err_pulse`  out  1  one-cycle mismatch indication
- `err_sticky`  out  1  at least one mismatch since the last reset or `clr`
- `err_count`  out  CNTW  mismatching cycles, saturating
- `sample_count`  out  CNTW  compared cycles, saturating
- `first_err_idx`  out  CNTW  `sample_count` value at the first mismatch
- `first_err_xor`  out  SIZEOUT  `gold ^ accum_out` at the first mismatch

## Operation
Shadow model. Updates only on `ce`=1 cycles; it mirrors the MAC pipeline register for register:
- `a_d1 <= a`
- `sload_d1 <= sload`
- `prod_d2 <= a_d1 * COEF`, 2·SIZEIN bits signed, sign-extended to SIZEOUT
- `gold <= (sload_d1 ? 0 : gold) + prod_d2`, wrapping mod 2^SIZEOUT

Arming:
- The MAC has no reset, so its accumulator is undefined until the first restart.
- `armed` is 0 after reset.
- `armed` is set on the first `ce` edge where `sload_d1`=1. At that edge `gold` reloads from zero.
- `armed` stays set until `rst_n`=0; `clr` does not affect it.

Compare (the compare cycle is any rising edge with `ce`=1 and `armed`=1):
- `mismatch = (accum_out != gold)`, using the current register values of both sides.
- `sample_count` increments, saturating at 2^CNTW − 1.
- On mismatch, `err_count` increments with the same saturation, and `err_sticky` is set.
- If `err_sticky` was 0, `first_err_idx` captures the pre-increment `sample_count` and `first_err_xor` captures `gold ^ accum_out`.
- A persistent accumulator corruption mismatches on every cycle until the next `sload` restart, and every such cycle is counted.

`ce`=0: shadow model, counters, captures and `armed` all hold; `err_pulse`=0.

`clr`=1:
- Zeros `err_count`, `sample_count`, `err_sticky`, `first_err_idx` and `first_err_xor`.
- `clr` wins over a simultaneous mismatch for every counter and capture.
- `err_pulse` still reflects that cycle's compare result.

## Timing
- Reset value (`rst_n`=0 at an edge): every output is 0, and `a_d1`, `sload_d1`, `prod_d2` and `gold` are also 0.
- Reset mid-campaign: all state is lost; the monitor re-arms only on a new `sload`.
- `err_pulse` is registered and high for exactly one clock, the clock after the compare edge that detected the mismatch.
- Counters and captures are visible one clock after their compare edge.
- End-to-end latency: a sample applied at ce-cycle t is reflected in `gold` after the 3rd `ce` edge. This equals the MAC latency, so the two stay aligned with no skew adjustment.
- `sload` back-to-back: each restart reloads `gold`; `armed` simply stays 1.
- `sload` while `ce`=0: ignored, matching the MAC.

## Structure
- Package `macc_mon_pkg`:
  - default `SIZEIN`/`SIZEOUT`/`COEF`/`CNTW` constants
  - `sat_inc` counter helper function
- Sub-module `macc_golden_model`: the `a_d1`/`sload_d1`/`prod_d2`/`gold` shadow pipeline.
- The top level holds arming, compare, counters and captures.

## Test plan
- **Clean stream.** Reset, then `ce`=1; `sload`=1 with `a`=1, then `sload`=0 with `a`=2, 3, and `accum_out` driven from a correct MAC. Required: `gold` steps 29, 87, 174; `armed`=1; `err_count`=0; `sample_count` increments once per cycle.
- **Bus-level single flip.** Flip `accum_out` bit 5 for one compare cycle. Required: one `err_pulse`; `err_count`=1; `first_err_xor`=0x20; `first_err_idx` equals `sample_count` at that cycle.
- **Accumulator corruption.** Flip the MAC's internal adder register bit 0 once, with `sload` restarting 4 cycles later. Required: `err_count`=4 and `first_err_xor`=0x1, with the capture unchanged by the later mismatches.
- **Gating.** `ce` low for 5 cycles mid-stream. Required: all outputs hold; no `err_pulse`; alignment is kept after `ce` returns.
- **Boundaries.**
  - `a`=−32768 → `prod`=−950272, correct sign extension.
  - With `CNTW`=4, forced mismatches saturate `err_count` at 15.
- **Control priority.**
  - `clr` coincident with a mismatch: counters are 0 and `err_pulse`=1.
  - `rst_n`=0 mid-stream: `armed`=0, and no compare occurs until the next `sload`.
